// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline stages.
//   XLEN          : architectural register / address width
//   RESET_PC      : first fetch address after reset
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) used as a bubble
//   fetch_entry_t : {pc, instruction} pair carried from fetch to decode
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0100_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries between imem and decode.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-low reset
//   push, push_data : write one entry (accepted when not full, or full with pop)
//   pop             : remove the head entry (ignored when empty)
//   flush           : discard all entries; wins over push and pop
//   full, empty     : occupancy flags
//   count           : number of valid entries
//   head            : oldest entry, straight from the storage registers
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output fetch_entry_t              head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  fetch_entry_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // At full a simultaneous pop frees the slot being written.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order or other blocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only observed after
  // being written, and leaving it unreset lets it map to plain flops/RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding decode.
// Generates sequential word addresses towards a variable-latency imem port,
// buffers returned words in a prefetch FIFO and presents them to decode.
// Redirects from execute flush the FIFO and drop responses still in flight.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   imem_req_*          : request channel (valid/ready, word-aligned address)
//   imem_rsp_*          : in-order response channel, no backpressure
//   redirect_valid/_pc  : taken branch / jump target from execute
//   out_*               : valid/ready instruction stream to decode
module fetch_unit
  import cpu_pkg::XLEN;
  import cpu_pkg::fetch_entry_t;
#(
  parameter logic [31:0] RESET_PC        = cpu_pkg::RESET_PC,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = cpu_pkg::NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]             fetch_pc;
  logic [XLEN-1:0]             rsp_pc;
  logic [OW-1:0]               outstanding;
  logic [OW-1:0]               outstanding_nxt;
  logic [OW-1:0]               drop_count;
  logic                        run;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  fetch_entry_t                fifo_head;
  fetch_entry_t                fifo_push_data;
  logic                        req_fire;
  logic                        rsp_accept;
  logic                        rsp_keep;
  logic                        out_pop;
  logic [XLEN-1:0]             redirect_target;
  logic [31:0]                 credit_used;

  // Issue gating depends only on registers, so neither redirect_valid nor
  // out_ready reaches the request channel combinationally. Responses that
  // will be kept are counted as already occupying a FIFO slot, which is what
  // makes overflow impossible. 'run' holds requests off during reset.
  assign credit_used    = 32'(fifo_count) + 32'(outstanding) - 32'(drop_count);
  assign imem_req_valid = run && (outstanding < OW'(MAX_OUTSTANDING))
                          && (credit_used < 32'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept      = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep        = rsp_accept && (drop_count == '0);
  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(rsp_accept);
  assign redirect_target = redirect_pc & ~32'd3;
  assign out_pop         = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc   <= redirect_target;
        rsp_pc     <= redirect_target;
        drop_count <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_accept && (drop_count != '0)) drop_count <= drop_count - OW'(1);
      end
    end
  end

  assign fifo_push_data = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (fifo_push_data),
    .pop       (out_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign out_valid = !fifo_empty;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    out_pc          = '0;
    out_instruction = NOP_INSTR;
    if (!fifo_empty) begin
      out_pc          = fifo_head.pc;
      out_instruction = fifo_head.instr;
    end
  end

  // Simulation-only error flags: stray response, and a kept word meeting a
  // full FIFO (the credit rule must prevent the latter).
  assert property (@(posedge clock) disable iff (!reset)
                   !(imem_rsp_valid && (outstanding == '0)));
  assert property (@(posedge clock) disable iff (!reset)
                   !(rsp_keep && fifo_full && !out_pop && !redirect_valid));

endmodule
